// File: rtl/fp_add_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_sched_pkg
//  Description : Shared definitions for the two-channel FP add/sub scheduler:
//                default pipeline depth, channel-id type, FP32 field widths
//                and the width of the per-channel outstanding counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package fp_add_sched_pkg;

  // Default issue-to-result depth of the external add/sub pipeline.
  localparam int unsigned c_LATENCY_DEFAULT = 4;

  // Channel identifier: two channels, so a single bit.
  typedef logic ch_id_t;

  // IEEE-754 single-precision field widths.
  localparam int unsigned c_FP_SIGN_W = 1;
  localparam int unsigned c_FP_EXP_W  = 8;
  localparam int unsigned c_FP_MAN_W  = 23;
  localparam int unsigned c_FP_W      = c_FP_SIGN_W + c_FP_EXP_W + c_FP_MAN_W;

  // Outstanding-operation counter width; LATENCY <= 8 always fits.
  localparam int unsigned c_CNT_W = 4;

endpackage : fp_add_sched_pkg
`default_nettype wire

// File: rtl/fp_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : fp_rr_arb2
//  Description : Two-requester round-robin arbiter with a 1-bit priority
//                pointer. On contention the pointer channel wins; after any
//                grant to channel k the pointer moves to channel 1-k.
//  Ports       : clk, rst_n      - clock, async active-low reset
//                eligible[1:0]   - per-channel request (already qualified)
//                grant[1:0]      - one-hot (or zero) grant, combinational
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_rr_arb2
  import fp_add_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] eligible,
  output logic [1:0] grant
);

  ch_id_t ptr_q;
  ch_id_t ptr_d;

  always_comb begin
    grant = 2'b00;
    ptr_d = ptr_q;
    unique case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
    // Hand priority to the other channel after a grant; hold otherwise.
    if (grant[0]) ptr_d = 1'b1;
    if (grant[1]) ptr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : fp_rr_arb2
`default_nettype wire

// File: rtl/fp_add_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fp_add_sched
//  Description : Issue scheduler for a shared LATENCY-deep FP32 add/sub
//                pipeline serving two request/response channels. Tracks
//                {valid, channel} for every pipeline slot, routes the final
//                stage result to its channel and stalls the whole pipeline
//                while the head result is not accepted.
//  Ports       : clk, rst_n                   - clock, async active-low reset
//                req_valid/req_ready[1:0]     - per-channel request handshake
//                req_a0/req_b0/req_a1/req_b1  - FP32 operands per channel
//                req_sub[1:0]                 - 1 = subtract
//                ch_en[1:0]                   - channel enable for new grants
//                pipe_en                      - global datapath advance enable
//                issue_valid/_a/_b/_sub       - operands into datapath stage 1
//                res_in                       - datapath final-stage result
//                rsp_valid/rsp_ready[1:0]     - per-channel response handshake
//                rsp_data                     - response data (= res_in)
//                inflight0/inflight1          - outstanding ops per channel
//                idle                         - nothing in flight
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_add_sched
  import fp_add_sched_pkg::*;
#(
  parameter int unsigned LATENCY = c_LATENCY_DEFAULT  // legal range 2..8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [c_FP_W-1:0]   req_a0,
  input  logic [c_FP_W-1:0]   req_b0,
  input  logic [c_FP_W-1:0]   req_a1,
  input  logic [c_FP_W-1:0]   req_b1,
  input  logic [1:0]          req_sub,
  input  logic [1:0]          ch_en,
  output logic                pipe_en,
  output logic                issue_valid,
  output logic [c_FP_W-1:0]   issue_a,
  output logic [c_FP_W-1:0]   issue_b,
  output logic                issue_sub,
  input  logic [c_FP_W-1:0]   res_in,
  output logic [1:0]          rsp_valid,
  input  logic [1:0]          rsp_ready,
  output logic [c_FP_W-1:0]   rsp_data,
  output logic [c_CNT_W-1:0]  inflight0,
  output logic [c_CNT_W-1:0]  inflight1,
  output logic                idle
);

  // Tracking shift register, one entry per datapath stage.
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] tag_q;

  logic               w_head_vld;
  ch_id_t             w_head_tag;
  logic [1:0]         w_eligible;
  logic [1:0]         w_grant;
  ch_id_t             w_grant_ch;
  logic [1:0]         w_req_xfer;
  logic [1:0]         w_rsp_xfer;
  logic [c_CNT_W-1:0] w_inflight [2];

  assign w_head_vld = vld_q[LATENCY-1];
  assign w_head_tag = tag_q[LATENCY-1];

  // The pipeline only stalls when a valid head result is refused.
  assign pipe_en = !w_head_vld | rsp_ready[w_head_tag];

  // rst_n gates eligibility so no handshake is offered while in reset.
  assign w_eligible = req_valid & ch_en & {2{pipe_en & rst_n}};

  fp_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .eligible (w_eligible),
    .grant    (w_grant)
  );

  assign req_ready   = w_grant;
  assign w_grant_ch  = w_grant[1];
  assign issue_valid = |w_grant;
  assign issue_a     = w_grant_ch ? req_a1 : req_a0;
  assign issue_b     = w_grant_ch ? req_b1 : req_b0;
  assign issue_sub   = req_sub[w_grant_ch];

  assign rsp_data = res_in;
  assign idle     = ~|vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      tag_q <= '0;
    end else if (pipe_en) begin
      vld_q <= {vld_q[LATENCY-2:0], issue_valid};
      tag_q <= {tag_q[LATENCY-2:0], w_grant_ch};
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_ch
    logic [c_CNT_W-1:0] cnt_q;

    assign rsp_valid[k]  = w_head_vld & (w_head_tag == ch_id_t'(k));
    assign w_req_xfer[k] = req_valid[k] & req_ready[k];
    assign w_rsp_xfer[k] = rsp_valid[k] & rsp_ready[k];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        unique case ({w_req_xfer[k], w_rsp_xfer[k]})
          2'b10:   cnt_q <= cnt_q + c_CNT_W'(1);
          2'b01:   cnt_q <= cnt_q - c_CNT_W'(1);
          default: cnt_q <= cnt_q;
        endcase
      end
    end

    assign w_inflight[k] = cnt_q;
  end

  assign inflight0 = w_inflight[0];
  assign inflight1 = w_inflight[1];

endmodule : fp_add_sched
`default_nettype wire

// File: tb/tb_fp_add_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_add_sched
//  Description : Self-checking bench for fp_add_sched. A small behavioural
//                datapath (LATENCY stages, advancing on pipe_en) returns the
//                hand-computed sum for each directed operand pair. Accepted
//                requests push their expected response onto a scoreboard;
//                a monitor pops and compares on every response transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_add_sched;

  localparam int LATENCY = 4;
  localparam int NV      = 12;

  // Directed vectors: a, b, sub, hand-computed FP32 result.
  localparam logic [31:0] VA [NV] = '{
    32'h3F800000, 32'h40400000, 32'h40A00000, 32'h41200000,
    32'h3F000000, 32'h40800000, 32'h41000000, 32'hC0000000,
    32'h3FC00000, 32'h42C80000, 32'h40E00000, 32'hBF800000};
  localparam logic [31:0] VB [NV] = '{
    32'h40000000, 32'h3F800000, 32'h40A00000, 32'h40000000,
    32'h3F000000, 32'h40800000, 32'h40800000, 32'h40000000,
    32'h3FC00000, 32'h42480000, 32'h3F800000, 32'h40400000};
  localparam logic        VS [NV] = '{
    1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic [31:0] VE [NV] = '{
    32'h40400000, 32'h40000000, 32'h41200000, 32'h41000000,
    32'h3F800000, 32'h00000000, 32'h41400000, 32'hC0800000,
    32'h40400000, 32'h42480000, 32'h41000000, 32'h40000000};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [1:0]  req_sub = 2'b00;
  logic [1:0]  ch_en;
  logic        pipe_en;
  logic        issue_valid;
  logic [31:0] issue_a, issue_b;
  logic        issue_sub;
  logic [31:0] res_in;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_data;
  logic [3:0]  inflight0, inflight1;
  logic        idle;

  always #5 clk = ~clk;

  fp_add_sched #(.LATENCY(LATENCY)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_sub(req_sub), .ch_en(ch_en), .pipe_en(pipe_en),
    .issue_valid(issue_valid), .issue_a(issue_a), .issue_b(issue_b),
    .issue_sub(issue_sub), .res_in(res_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .inflight0(inflight0), .inflight1(inflight1), .idle(idle));

  // ---------------- behavioural datapath ----------------
  logic [31:0] dp_a [LATENCY];
  logic [31:0] dp_b [LATENCY];
  logic        dp_s [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        dp_a[i] <= '0; dp_b[i] <= '0; dp_s[i] <= 1'b0;
      end
    end else if (pipe_en) begin
      dp_a[0] <= issue_a; dp_b[0] <= issue_b; dp_s[0] <= issue_sub;
      for (int i = 1; i < LATENCY; i++) begin
        dp_a[i] <= dp_a[i-1]; dp_b[i] <= dp_b[i-1]; dp_s[i] <= dp_s[i-1];
      end
    end
  end

  function automatic logic [31:0] dp_result(logic [31:0] a, logic [31:0] b, logic s);
    for (int i = 0; i < NV; i++)
      if (VA[i] == a && VB[i] == b && VS[i] == s) return VE[i];
    return 32'hDEADBEEF;
  endfunction

  always_comb res_in = dp_result(dp_a[LATENCY-1], dp_b[LATENCY-1], dp_s[LATENCY-1]);

  // ---------------- checking infrastructure ----------------
  typedef struct { logic ch; logic [31:0] data; int pe; } exp_t;
  exp_t sb [$];
  int   grant_log [$];
  int   chq [2][$];
  logic acc [2] = '{1'b0, 1'b0};
  int   pe_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Channel drivers: hold each vector on the bus until it is accepted.
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        if (acc[k]) begin
          if (chq[k].size() > 0) void'(chq[k].pop_front());
          acc[k] = 1'b0;
        end
      end
      req_valid[0] = chq[0].size() > 0;
      if (chq[0].size() > 0) begin
        req_a0 = VA[chq[0][0]]; req_b0 = VB[chq[0][0]]; req_sub[0] = VS[chq[0][0]];
      end
      req_valid[1] = chq[1].size() > 0;
      if (chq[1].size() > 0) begin
        req_a1 = VA[chq[1][0]]; req_b1 = VB[chq[1][0]]; req_sub[1] = VS[chq[1][0]];
      end
    end
  end

  // Monitor: inputs settle #1 after posedge, so negedge sees the values the
  // next rising edge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("req_ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
      for (int k = 0; k < 2; k++) begin
        if (rsp_valid[k] && rsp_ready[k]) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp_ch", 32'(k), 32'hFFFFFFFF);
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("rsp_channel", 32'(k), 32'(e.ch));
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_latency", 32'(pe_cnt - e.pe), 32'(LATENCY));
          end
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (req_valid[k] && req_ready[k] && chq[k].size() > 0) begin
          sb.push_back('{ch: 1'(k), data: VE[chq[k][0]], pe: pe_cnt});
          grant_log.push_back(k);
          acc[k] = 1'b1;
        end
      end
      if (pipe_en) pe_cnt++;
    end
  end

  task automatic wait_drain(string name);
    int n = 0;
    while (n < 300 && !(chq[0].size() == 0 && chq[1].size() == 0 && idle && sb.size() == 0)) begin
      @(negedge clk); n++;
    end
    chk(name, 32'(n < 300), 32'd1);
  endtask

  task automatic reset_pulse();
    @(posedge clk); #2;
    rst_n = 1'b0;
    sb.delete();
    chq[0].delete(); chq[1].delete();
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int mark;
    logic [31:0] held;

    rst_n = 1'b0; rsp_ready = 2'b11; ch_en = 2'b11;
    chq[0].push_back(0);                         // single issue, 1 + 2
    repeat (3) @(posedge clk); #3;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_pipe_en", 32'(pipe_en), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_inflight0", 32'(inflight0), 32'd0);
    chk("rst_inflight1", 32'(inflight1), 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant_after_reset", 32'(req_ready), 32'd1);
    wait_drain("single_drain");
    chk("single_idle", 32'(idle), 32'd1);
    chk("single_inflight0", 32'(inflight0), 32'd0);

    // Contention from a fresh reset: strict alternation starting at ch0.
    reset_pulse();
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      chq[0].push_back(i);
      chq[1].push_back(i + 4);
    end
    wait_drain("contention_drain");
    chk("contention_grants", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < grant_log.size(); i++)
      chk("contention_order", 32'(grant_log[i]), 32'(i % 2));

    // Backpressure on a ch1 head result.
    rsp_ready = 2'b01;
    chq[1].push_back(9);
    n = 0;
    while (n < 50 && chq[1].size() != 0) begin @(posedge clk); #2; n++; end
    chq[0].push_back(10);
    chq[0].push_back(11);
    n = 0;
    while (n < 50 && !rsp_valid[1]) begin @(negedge clk); n++; end
    chk("bp_head_ch1", 32'(rsp_valid), 32'd2);
    @(posedge clk); #2;
    chq[0].push_back(3);
    @(negedge clk); @(negedge clk);
    held = rsp_data;
    chk("bp_held_value", held, 32'h42480000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_pipe_en", 32'(pipe_en), 32'd0);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_data_stable", rsp_data, held);
      chk("bp_req_pending", 32'(req_valid[0]), 32'd1);
    end
    @(posedge clk); #2;
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_release_pipe_en", 32'(pipe_en), 32'd1);
    chk("bp_release_issue", 32'(req_ready), 32'd1);
    wait_drain("bp_drain");

    // Disable ch0 while ch0 operations are in flight.
    chq[0].push_back(6);
    chq[0].push_back(7);
    n = 0;
    while (n < 50 && chq[0].size() != 0) begin @(posedge clk); #2; n++; end
    ch_en = 2'b10;
    mark = grant_log.size();
    chq[0].push_back(8); chq[0].push_back(9);
    chq[1].push_back(10); chq[1].push_back(11);
    n = 0;
    while (n < 100 && !(chq[1].size() == 0 && idle)) begin @(negedge clk); n++; end
    chk("dis_ch1_done", 32'(n < 100), 32'd1);
    chk("dis_inflight0", 32'(inflight0), 32'd0);
    chk("dis_ch0_pending", 32'(chq[0].size()), 32'd2);
    chk("dis_req_ready0", 32'(req_ready[0]), 32'd0);
    chk("dis_grants", 32'(grant_log.size() - mark), 32'd2);
    for (int i = mark; i < grant_log.size(); i++)
      chk("dis_grant_ch", 32'(grant_log[i]), 32'd1);
    ch_en = 2'b11;
    wait_drain("dis_drain");

    // Reset with three operations outstanding.
    rsp_ready = 2'b00;
    chq[0].push_back(0); chq[0].push_back(1);
    chq[1].push_back(2);
    n = 0;
    while (n < 50 && (inflight0 + inflight1) != 3) begin @(negedge clk); n++; end
    chk("mid_outstanding", 32'(inflight0 + inflight1), 32'd3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    sb.delete();
    #2;
    chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_inflight0", 32'(inflight0), 32'd0);
    chk("mid_inflight1", 32'(inflight1), 32'd0);
    chk("mid_idle", 32'(idle), 32'd1);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    repeat (20) @(negedge clk);
    chk("mid_no_stale", 32'(sb.size()), 32'd0);
    chk("mid_idle_after", 32'(idle), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fp_add_sched
`default_nettype wire

// File: doc/fp_add_sched.md
FP_ADD_SCHED -- requirements
Module: fp_add_sched

Interface
REQ-001 The block SHALL have parameter LATENCY, default 4, giving the pipeline depth in cycles from issue to result; the legal range is 2..8.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have ports req_valid[1:0] (input) and req_ready[1:0] (output): per-channel request handshake for channels 0 and 1.
REQ-005 The block SHALL have ports req_a0, req_b0, req_a1, req_b1, each input, 32 bits: IEEE-754 single-precision operands per channel.
REQ-006 The block SHALL have port req_sub[1:0], input: 1 selects subtract for that channel.
REQ-007 The block SHALL have port ch_en[1:0], input: channel enable; a disabled channel is never granted.
REQ-008 The block SHALL have port pipe_en, output, 1 bit: global advance enable for every add/sub pipeline stage register.
REQ-009 The block SHALL have ports issue_valid (output, 1 bit), issue_a and issue_b (outputs, 32 bits) and issue_sub (output, 1 bit): operands to stage 1, sampled by the datapath when pipe_en=1.
REQ-010 The block SHALL have port res_in, input, 32 bits: datapath final-stage result.
REQ-011 The block SHALL have ports rsp_valid[1:0] (output), rsp_ready[1:0] (input) and rsp_data, output, 32 bits: per-channel result handshake.
REQ-012 The block SHALL have ports inflight0 and inflight1, outputs, 4 bits each: per-channel outstanding operation count.
REQ-013 The block SHALL have port idle, output, 1 bit: asserted when no operation is in flight.

Function
REQ-014 The block SHALL keep a tracking shift register of LATENCY entries {vld, tag}, advancing only when pipe_en=1; entry 0 loads {issue_valid, granted channel}.
REQ-015 The block SHALL drive rsp_valid[k] = vld[LATENCY-1] & (tag[LATENCY-1]==k), and rsp_data = res_in.
REQ-016 The block SHALL drive pipe_en = !vld[LATENCY-1] | rsp_ready[tag[LATENCY-1]]; a stalled result SHALL hold both the pipeline and rsp_data stable.
REQ-017 The block SHALL generate issue_valid/issue_a/issue_b/issue_sub combinationally from the granted channel; issue_valid is 0 when no channel is eligible.
REQ-018 Channel k SHALL be eligible when req_valid[k] & ch_en[k] & pipe_en are all 1.
REQ-019 Arbitration SHALL be round-robin with a 1-bit priority pointer: if both channels are eligible, the pointer channel is granted.
REQ-020 After any grant to channel k, the pointer SHALL move to channel 1-k; with no grant, the pointer SHALL hold.
REQ-021 The block SHALL assert req_ready[k] only in a cycle in which channel k is granted; at most one req_ready bit SHALL be high per cycle.
REQ-022 A transfer SHALL occur on req_valid[k] & req_ready[k]; the result of that transfer SHALL appear on rsp_valid[k] exactly LATENCY pipe_en-high cycles later.
REQ-023 inflight_k SHALL increment on a channel-k request transfer and decrement on a channel-k response transfer; on a simultaneous transfer it SHALL hold.
REQ-024 idle SHALL equal NOR of all vld bits.
REQ-025 Responses SHALL retire in issue order; there is no reordering between channels.
REQ-026 Deasserting ch_en[k] SHALL block only new grants; in-flight channel-k operations SHALL complete normally.
REQ-027 A stall on one channel's response SHALL also block issue on the other channel (head-of-line blocking).

Reset
REQ-028 While rst_n=0, all vld bits and tags SHALL be 0, the pointer SHALL select channel 0, and inflight0=inflight1=0.
REQ-029 Consequently, during reset rsp_valid=0, req_ready=0, issue_valid=0, pipe_en=1 and idle=1.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight operations with no response delivered; the datapath registers are reset by the same rst_n.
REQ-031 Deassertion of rst_n SHALL be synchronized externally; the first grant is possible in the first clock after release.

Structure
REQ-032 The shared FP package SHALL hold the LATENCY default, the channel-id type (1 bit), and the FP32 field widths (sign 1, exponent 8, mantissa 23).
REQ-033 The round-robin arbiter SHALL be one sub-module, fp_rr_arb2: inputs eligible[1:0], outputs grant[1:0], holding the pointer register.
REQ-034 The tracking shift register and counters SHALL remain in fp_add_sched.

Verification
REQ-035 Single issue: ch0 sends a=0x3F800000, b=0x40000000, sub=0, with rsp_ready=11 -> rsp_valid[0] is high exactly 4 cycles later, rsp_data=0x40400000, and idle returns to 1.
REQ-036 Contention: both channels valid continuously after reset -> grants ch0,ch1,ch0,ch1…, and each channel receives 50% of the issue slots.
REQ-037 Backpressure: rsp_ready[1]=0 while a ch1 result sits at the head -> pipe_en=0, no req_ready, rsp_data stable; releasing rsp_ready[1] delivers it and resumes issue on the next cycle.
REQ-038 Disable: ch_en=10 with both channels valid -> only ch1 is granted; previously issued ch0 operations still return and inflight0 reaches 0.
REQ-039 Reset mid-flight: three operations outstanding, pulse rst_n low -> all rsp_valid=0, inflight0=inflight1=0, idle=1, and no stale response appears afterward.
